// File: rtl/multi_warp_fetcher.sv
// Shared instruction fetch front-end: per-warp fetch FSMs, round-robin arbitration, one outstanding request.
// Optional FETCHER_LAST_PC_CACHE_EN: per-warp last-PC tag lets a repeated fetch complete without memory.

package common_pkg;
    typedef enum logic [1:0] {
        WARP_IDLE   = 2'd0,
        WARP_FETCH  = 2'd1,
        WARP_DECODE = 2'd2,
        WARP_EXEC   = 2'd3
    } warp_state_t;

    typedef logic [31:0] instr_mem_addr_t;
    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        FETCHER_IDLE     = 2'd0,
        FETCHER_FETCHING = 2'd1,
        FETCHER_DONE     = 2'd2
    } fetcher_state_t;
endpackage

module multi_warp_fetcher #(
    parameter int NUM_WARPS = 4,
    parameter int WARP_ID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  common_pkg::warp_state_t     warp_state [NUM_WARPS],
    input  common_pkg::instr_mem_addr_t pc [NUM_WARPS],
    output logic                        mem_valid,
    output common_pkg::instr_mem_addr_t mem_addr,
    input  logic                        mem_resp_ready,
    input  common_pkg::instr_t          mem_resp_data,
    output common_pkg::fetcher_state_t  out_fetcher_state [NUM_WARPS],
    output common_pkg::instr_t          out_instr [NUM_WARPS]
);
    import common_pkg::*;

    fetcher_state_t        state_q [NUM_WARPS];
    fetcher_state_t        state_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]  pending_q, pending_d;
    logic                  mem_valid_q, mem_valid_d;
    instr_mem_addr_t       mem_addr_q, mem_addr_d;
    logic [WARP_ID_W-1:0]  owner_q, owner_d;
    logic [WARP_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    instr_t                out_instr_q [NUM_WARPS];
    instr_t                out_instr_d [NUM_WARPS];

    logic [NUM_WARPS-1:0]  hit;
    logic [NUM_WARPS-1:0]  req;
    logic                  grant_vld;
    logic [WARP_ID_W-1:0]  grant_id;
    logic [WARP_ID_W-1:0]  scan_idx;
    logic                  resp_fire;

`ifdef FETCHER_LAST_PC_CACHE_EN
    instr_mem_addr_t       last_pc_q [NUM_WARPS];
    instr_mem_addr_t       last_pc_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]  last_pc_vld_q, last_pc_vld_d;

    always_comb begin
        hit = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            hit[w] = last_pc_vld_q[w] && (pc[w] == last_pc_q[w]);
        end
    end
`else
    assign hit = '0;
`endif

    assign resp_fire = mem_resp_ready && mem_valid_q;

    // Hits bypass arbitration entirely; issued FETCHING warps no longer request.
    always_comb begin
        req = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            req[w] = ((state_q[w] == FETCHER_IDLE) && (warp_state[w] == WARP_FETCH) && !hit[w])
                  || ((state_q[w] == FETCHER_FETCHING) && pending_q[w]);
        end
    end

    // A busy bus (including the response edge) blocks any grant.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        if (!mem_valid_q) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                scan_idx = WARP_ID_W'((int'(rr_ptr_q) + i) % NUM_WARPS);
                if (!grant_vld && req[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = scan_idx;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        out_instr_d = out_instr_q;
`ifdef FETCHER_LAST_PC_CACHE_EN
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
`endif
        for (int w = 0; w < NUM_WARPS; w++) begin
            case (state_q[w])
                FETCHER_IDLE: begin
                    if (warp_state[w] == WARP_FETCH) begin
                        if (hit[w]) begin
                            state_d[w] = FETCHER_DONE;
                        end else begin
                            state_d[w]   = FETCHER_FETCHING;
                            pending_d[w] = !(grant_vld && (grant_id == WARP_ID_W'(w)));
                        end
                    end
                end
                FETCHER_FETCHING: begin
                    if (grant_vld && (grant_id == WARP_ID_W'(w))) begin
                        pending_d[w] = 1'b0;
                    end
                    if (resp_fire && (owner_q == WARP_ID_W'(w))) begin
                        state_d[w] = FETCHER_DONE;
                    end
                end
                FETCHER_DONE: begin
                    if (warp_state[w] == WARP_DECODE) begin
                        state_d[w] = FETCHER_IDLE;
                    end
                end
                default: begin
                    state_d[w]   = FETCHER_IDLE;
                    pending_d[w] = 1'b0;
                end
            endcase
        end

        if (resp_fire) begin
            mem_valid_d          = 1'b0;
            out_instr_d[owner_q] = mem_resp_data;
`ifdef FETCHER_LAST_PC_CACHE_EN
            last_pc_d[owner_q]     = mem_addr_q;
            last_pc_vld_d[owner_q] = 1'b1;
`endif
        end

        if (grant_vld) begin
            mem_valid_d = 1'b1;
            mem_addr_d  = pc[grant_id];
            owner_d     = grant_id;
            rr_ptr_d    = (int'(grant_id) == NUM_WARPS - 1) ? '0 : grant_id + WARP_ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state_q[w]     <= FETCHER_IDLE;
                out_instr_q[w] <= '0;
`ifdef FETCHER_LAST_PC_CACHE_EN
                last_pc_q[w]   <= '0;
`endif
            end
            pending_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
`ifdef FETCHER_LAST_PC_CACHE_EN
            last_pc_vld_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_instr_q <= out_instr_d;
            pending_q   <= pending_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef FETCHER_LAST_PC_CACHE_EN
            last_pc_q     <= last_pc_d;
            last_pc_vld_q <= last_pc_vld_d;
`endif
        end
    end

    always_comb begin
        mem_valid         = mem_valid_q;
        mem_addr          = mem_addr_q;
        out_fetcher_state = state_q;
        out_instr         = out_instr_q;
    end

endmodule

// File: tb/tb_multi_warp_fetcher.sv
// Directed bench for multi_warp_fetcher: single fetch, round-robin order, reset mid-request,
// spurious responses and the repeated-PC case (expectations follow FETCHER_LAST_PC_CACHE_EN).
module tb_multi_warp_fetcher;
    import common_pkg::*;

    localparam int NW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    warp_state_t     warp_state [NW];
    instr_mem_addr_t pc [NW];
    logic            mem_valid;
    instr_mem_addr_t mem_addr;
    logic            mem_resp_ready = 1'b0;
    instr_t          mem_resp_data = '0;
    fetcher_state_t  out_fetcher_state [NW];
    instr_t          out_instr [NW];

    int vec_cnt = 0;
    int err_cnt = 0;
    int req_cnt = 0;
    logic mem_valid_prev = 1'b0;

    multi_warp_fetcher #(.NUM_WARPS(NW)) dut (
        .clk               (clk),
        .reset             (reset),
        .warp_state        (warp_state),
        .pc                (pc),
        .mem_valid         (mem_valid),
        .mem_addr          (mem_addr),
        .mem_resp_ready    (mem_resp_ready),
        .mem_resp_data     (mem_resp_data),
        .out_fetcher_state (out_fetcher_state),
        .out_instr         (out_instr)
    );

    always #5 clk = ~clk;

    // Count memory requests as rising edges of mem_valid.
    always @(negedge clk) begin
        if (mem_valid && !mem_valid_prev) req_cnt++;
        mem_valid_prev = mem_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NW; i++) warp_state[i] = WARP_IDLE;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a request, check its address, answer after `delay` extra cycles.
    task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input int wid, input int delay);
        int n;
        n = 0;
        while (!mem_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 64'(mem_valid), 64'd1);
        check({tag, "_addr"}, 64'(mem_addr), 64'(addr));
        repeat (delay) step();
        mem_resp_ready = 1'b1;
        mem_resp_data  = data;
        step();
        mem_resp_ready = 1'b0;
        check({tag, "_gap"}, 64'(mem_valid), 64'd0);
        check({tag, "_done"}, 64'(out_fetcher_state[wid]), 64'(FETCHER_DONE));
        check({tag, "_data"}, 64'(out_instr[wid]), 64'(data));
    endtask

    initial begin
        int base;
        idle_all();
        for (int i = 0; i < NW; i++) pc[i] = '0;

        // Reset state
        do_reset();
        check("rst_valid", 64'(mem_valid), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_state0", 64'(out_fetcher_state[0]), 64'(FETCHER_IDLE));
        check("rst_instr3", 64'(out_instr[3]), 64'd0);

        // Single warp, response 3 cycles after mem_valid
        warp_state[0] = WARP_FETCH;
        pc[0] = 32'h10;
        step();
        check("w0_fetching", 64'(out_fetcher_state[0]), 64'(FETCHER_FETCHING));
        idle_all();
        serve("w0", 32'h10, 32'hDEADBEEF, 0, 2);
        warp_state[0] = WARP_DECODE;
        step();
        check("w0_decode_idle", 64'(out_fetcher_state[0]), 64'(FETCHER_IDLE));
        idle_all();

        // Spurious response while bus idle
        mem_resp_ready = 1'b1;
        mem_resp_data  = 32'h1234;
        step();
        mem_resp_ready = 1'b0;
        check("spur_state", 64'(out_fetcher_state[0]), 64'(FETCHER_IDLE));
        check("spur_instr", 64'(out_instr[0]), 64'hDEADBEEF);
        check("spur_valid", 64'(mem_valid), 64'd0);

        // Four simultaneous requesters, expect order 0,1,2,3
        do_reset();
        for (int i = 0; i < NW; i++) begin
            warp_state[i] = WARP_FETCH;
            pc[i] = 32'(4 * i);
        end
        step();
        check("all_w3_fetching", 64'(out_fetcher_state[3]), 64'(FETCHER_FETCHING));
        idle_all();
        for (int k = 0; k < NW; k++) begin
            serve($sformatf("rr%0d", k), 32'(4 * k), 32'hA000_0000 + 32'(k), k, 0);
        end
        for (int k = 0; k < NW; k++) begin
            check($sformatf("rr_hold%0d", k), 64'(out_instr[k]), 64'(32'hA000_0000 + 32'(k)));
        end

        // rr_ptr moved to 2 by granting warp 1; warps 0 and 3 pending -> 3 then 0
        do_reset();
        pc[0] = 32'h100;
        pc[1] = 32'h104;
        pc[3] = 32'h10C;
        warp_state[1] = WARP_FETCH;
        step();
        idle_all();
        warp_state[0] = WARP_FETCH;
        warp_state[3] = WARP_FETCH;
        step();
        idle_all();
        check("ptr_w0_pending", 64'(out_fetcher_state[0]), 64'(FETCHER_FETCHING));
        serve("ptr_w1", 32'h104, 32'hB1, 1, 0);
        serve("ptr_w3", 32'h10C, 32'hB3, 3, 0);
        serve("ptr_w0", 32'h100, 32'hB0, 0, 0);

        // Reset during an outstanding request; late response dropped
        warp_state[2] = WARP_FETCH;
        pc[2] = 32'h200;
        step();
        idle_all();
        check("mid_valid", 64'(mem_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_resp_ready = 1'b1;
        mem_resp_data  = 32'hBAD0BAD0;
        check("mid_rst_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_instr0", 64'(out_instr[0]), 64'd0);
        check("mid_rst_state3", 64'(out_fetcher_state[3]), 64'(FETCHER_IDLE));
        step();
        mem_resp_ready = 1'b0;
        check("late_state2", 64'(out_fetcher_state[2]), 64'(FETCHER_IDLE));
        check("late_instr2", 64'(out_instr[2]), 64'd0);
        check("late_valid", 64'(mem_valid), 64'd0);

        // Warp 1 fetches 0x20 twice
        base = req_cnt;
        warp_state[1] = WARP_FETCH;
        pc[1] = 32'h20;
        step();
        idle_all();
        serve("pc1", 32'h20, 32'hCAFE0001, 1, 0);
        check("pc1_reqs", 64'(req_cnt - base), 64'd1);
        warp_state[1] = WARP_DECODE;
        step();
        check("pc1_idle", 64'(out_fetcher_state[1]), 64'(FETCHER_IDLE));
        warp_state[1] = WARP_FETCH;
        step();
        idle_all();
`ifdef FETCHER_LAST_PC_CACHE_EN
        check("pc2_hit_done", 64'(out_fetcher_state[1]), 64'(FETCHER_DONE));
        check("pc2_hit_valid", 64'(mem_valid), 64'd0);
        step();
        check("pc2_hit_valid2", 64'(mem_valid), 64'd0);
        check("pc2_reqs", 64'(req_cnt - base), 64'd1);
        check("pc2_instr", 64'(out_instr[1]), 64'hCAFE0001);
`else
        check("pc2_fetching", 64'(out_fetcher_state[1]), 64'(FETCHER_FETCHING));
        serve("pc2", 32'h20, 32'hCAFE0002, 1, 0);
        check("pc2_reqs", 64'(req_cnt - base), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
